// File: rtl/pixel_frame_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_frame_streamer_pkg
// Brief    : State encoding and frame-geometry helpers for the pixel streamer.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_frame_streamer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_STREAM = 3'd1;
  localparam state_t ST_GAP    = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  localparam int unsigned DEFAULT_ROW_SIZE    = 28;
  localparam int unsigned DEFAULT_COLUMN_SIZE = 28;

  function automatic int unsigned frame_pixels(input int unsigned rows, input int unsigned cols);
    return rows * cols;
  endfunction

  // One result per 2x2 pool window over the valid 3x3-conv output.
  function automatic int unsigned pooled_outputs(input int unsigned rows, input int unsigned cols);
    return ((rows - 2) / 2) * ((cols - 2) / 2);
  endfunction

  localparam int unsigned FRAME_PIXELS = frame_pixels(DEFAULT_ROW_SIZE, DEFAULT_COLUMN_SIZE);

endpackage
`default_nettype wire

// File: rtl/pixel_frame_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_frame_streamer_if
// Brief    : Load port, control and pixel-stream signals of the frame streamer.
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_frame_streamer_if #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned GAP_WIDTH     = 4
) ();

  logic                     wr_en;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [IN_DATA_WIDTH-1:0] wr_data;
  logic                     start;
  logic [GAP_WIDTH-1:0]     gap;
  logic                     max_valid;
  logic [IN_DATA_WIDTH-1:0] pixel_out;
  logic                     pixel_valid;
  logic                     busy;
  logic                     done;
  logic                     timeout_err;
  logic [ADDR_WIDTH-1:0]    result_count;

  modport master (
    output wr_en, wr_addr, wr_data, start, gap, max_valid,
    input  pixel_out, pixel_valid, busy, done, timeout_err, result_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, gap, max_valid,
    output pixel_out, pixel_valid, busy, done, timeout_err, result_count
  );

endinterface
`default_nettype wire

// File: rtl/pixel_frame_streamer_frame_ram.sv
`default_nettype none
// ============================================================================
// Module   : frame_ram
// Brief    : Simple dual-address frame store, synchronous write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module frame_ram
  import pixel_frame_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  wire logic                  clock,
  input  wire logic                  we_i,
  input  wire logic [ADDR_WIDTH-1:0] waddr_i,
  input  wire logic [DATA_WIDTH-1:0] wdata_i,
  input  wire logic                  re_i,
  input  wire logic [ADDR_WIDTH-1:0] raddr_i,
  output      logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // No reset on the array or read register so the store maps onto block RAM.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/pixel_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_frame_streamer
// Brief    : Streams a stored frame in raster order and counts pooled results.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_frame_streamer
  import pixel_frame_streamer_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH    = 8,
  parameter int unsigned ROW_SIZE         = 28,
  parameter int unsigned COLUMN_SIZE      = 28,
  parameter int unsigned EXPECTED_OUTPUTS = pooled_outputs(ROW_SIZE, COLUMN_SIZE),
  parameter int unsigned GAP_WIDTH        = 4,
  parameter int unsigned DRAIN_TIMEOUT    = 4096,
  parameter int unsigned ADDR_WIDTH       = 10
) (
  input wire logic                  clock,
  input wire logic                  reset,
  pixel_frame_streamer_if.slave     bus
);

  localparam int unsigned FRAME     = frame_pixels(ROW_SIZE, COLUMN_SIZE);
  localparam int unsigned TMR_WIDTH = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [ADDR_WIDTH:0]   FRAME_LIMIT = (ADDR_WIDTH + 1)'(FRAME);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(FRAME - 1);
  localparam logic [ADDR_WIDTH-1:0] EXP_COUNT   = ADDR_WIDTH'(EXPECTED_OUTPUTS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE     = GAP_WIDTH'(1);
  localparam logic [TMR_WIDTH-1:0]  TMR_ONE     = TMR_WIDTH'(1);
  localparam logic [TMR_WIDTH-1:0]  TMR_LAST    = TMR_WIDTH'(DRAIN_TIMEOUT - 1);

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic [GAP_WIDTH-1:0]     gap_q, gap_d;
  logic [GAP_WIDTH-1:0]     gap_cnt_q, gap_cnt_d;
  logic [TMR_WIDTH-1:0]     tmr_q, tmr_d;
  logic [ADDR_WIDTH-1:0]    count_q, count_d;
  logic                     terr_q, terr_d;
  logic                     rd_valid_q;
  logic                     pix_valid_q;
  logic [IN_DATA_WIDTH-1:0] pix_q;

  logic                     ram_we, ram_re;
  logic [IN_DATA_WIDTH-1:0] ram_rdata;
  logic                     gap_last, success;

  assign gap_last = (gap_cnt_q == (gap_q - GAP_ONE));
  assign success  = (count_d == EXP_COUNT);

  frame_ram #(
    .DATA_WIDTH (IN_DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_frame_ram (
    .clock   (clock),
    .we_i    (ram_we),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .re_i    (ram_re),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_STREAM;
      ST_STREAM: begin
        if (rd_addr_q == LAST_ADDR) state_d = ST_DRAIN;
        else if (gap_q != '0)       state_d = ST_GAP;
      end
      ST_GAP:    if (gap_last) state_d = ST_STREAM;
      ST_DRAIN:  if (success || (tmr_q == TMR_LAST)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_re = (state_q == ST_STREAM);
    ram_we = bus.wr_en && (state_q == ST_IDLE) && ({1'b0, bus.wr_addr} < FRAME_LIMIT);
  end

  // Counters; the result count uses its next value so the final pulse ends DRAIN at once.
  always_comb begin
    rd_addr_d = rd_addr_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    tmr_d     = '0;
    count_d   = count_q;
    terr_d    = terr_q;
    if (bus.max_valid && (count_q != EXP_COUNT) &&
        ((state_q == ST_STREAM) || (state_q == ST_GAP) || (state_q == ST_DRAIN))) begin
      count_d = count_q + ADDR_ONE;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          gap_d     = bus.gap;
          gap_cnt_d = '0;
          rd_addr_d = '0;
          count_d   = '0;
          terr_d    = 1'b0;
        end
      end
      ST_STREAM: begin
        gap_cnt_d = '0;
        if ((rd_addr_q != LAST_ADDR) && (gap_q == '0)) rd_addr_d = rd_addr_q + ADDR_ONE;
      end
      ST_GAP: begin
        if (gap_last) begin
          gap_cnt_d = '0;
          rd_addr_d = rd_addr_q + ADDR_ONE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_ONE;
        end
      end
      ST_DRAIN: begin
        tmr_d = tmr_q + TMR_ONE;
        if (!success && (tmr_q == TMR_LAST)) terr_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr_q   <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      tmr_q       <= '0;
      count_q     <= '0;
      terr_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_q       <= '0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      tmr_q       <= tmr_d;
      count_q     <= count_d;
      terr_q      <= terr_d;
      rd_valid_q  <= ram_re;
      pix_valid_q <= rd_valid_q;
      if (rd_valid_q) pix_q <= ram_rdata;
    end
  end

  always_comb begin
    bus.busy         = (state_q != ST_IDLE);
    bus.done         = (state_q == ST_DONE);
    bus.pixel_out    = pix_q;
    bus.pixel_valid  = pix_valid_q;
    bus.timeout_err  = terr_q;
    bus.result_count = count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_frame_streamer
// Brief    : Directed self-checking bench for the pixel frame streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_streamer;

  localparam int FRAME  = 784;
  localparam int BUDGET = 8000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pixel_frame_streamer_if #(.IN_DATA_WIDTH(8), .ADDR_WIDTH(10), .GAP_WIDTH(4)) bus ();

  pixel_frame_streamer #(
    .IN_DATA_WIDTH    (8),
    .ROW_SIZE         (28),
    .COLUMN_SIZE      (28),
    .EXPECTED_OUTPUTS (169),
    .GAP_WIDTH        (4),
    .DRAIN_TIMEOUT    (4096),
    .ADDR_WIDTH       (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] model [0:FRAME-1];

  int o_pix, o_bad_data, o_bad_space, o_bad_hold, o_first, o_last, o_busy_low;
  int o_done_cnt, o_done_cyc, o_cnt_done, o_terr_done;
  int o_start_busy, o_start_terr, o_start_cnt, o_after_done, o_after_busy;
  int o_timed_out, o_aborted, o_abort_valid, o_abort_busy;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts a frame and observes it until done, abort or the cycle budget.
  task automatic run_frame(input int g, input int npulse, input int pfirst, input int pper,
                           input int inject_at, input int abort_at);
    int cyc;
    bit fin;
    logic [7:0] last_pix;
    o_pix = 0; o_bad_data = 0; o_bad_space = 0; o_bad_hold = 0; o_first = -1; o_last = -1;
    o_busy_low = 0; o_done_cnt = 0; o_done_cyc = -1; o_cnt_done = -1; o_terr_done = -1;
    o_after_done = -1; o_after_busy = -1; o_timed_out = 0; o_aborted = 0;
    o_abort_valid = -1; o_abort_busy = -1;
    last_pix = 8'h00;
    bus.start = 1'b1; bus.gap = 4'(g);
    tick();
    bus.start = 1'b0;
    o_start_busy = int'(bus.busy); o_start_terr = int'(bus.timeout_err);
    o_start_cnt = int'(bus.result_count);
    cyc = 0; fin = 1'b0;
    while (!fin && cyc < BUDGET) begin
      cyc++;
      bus.max_valid = (npulse > 0) && (cyc >= pfirst) && (((cyc - pfirst) % pper) == 0) &&
                      (((cyc - pfirst) / pper) < npulse);
      if (cyc == inject_at) begin
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = 8'hAA;
      end
      tick();
      bus.max_valid = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
      if (bus.pixel_valid === 1'b1) begin
        if (o_pix >= FRAME || bus.pixel_out !== model[o_pix]) o_bad_data++;
        if (o_last >= 0 && (cyc - o_last) != g + 1) o_bad_space++;
        if (o_first < 0) o_first = cyc;
        o_last = cyc; last_pix = bus.pixel_out; o_pix++;
      end else if (o_last >= 0 && bus.pixel_out !== last_pix) begin
        o_bad_hold++;
      end
      if (bus.done === 1'b1) begin
        o_done_cnt++;
        o_done_cyc = cyc; o_cnt_done = int'(bus.result_count); o_terr_done = int'(bus.timeout_err);
        fin = 1'b1;
      end else if (bus.busy !== 1'b1) begin
        o_busy_low++;
      end
      if (abort_at > 0 && o_pix == abort_at && !fin) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        o_aborted = 1; o_abort_valid = int'(bus.pixel_valid); o_abort_busy = int'(bus.busy);
        if (bus.done === 1'b1) o_done_cnt++;
        fin = 1'b1;
      end
    end
    if (!fin) o_timed_out = 1;
    tick();
    if (!o_aborted && !o_timed_out) begin
      o_after_done = int'(bus.done); o_after_busy = int'(bus.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0;
    bus.gap = '0; bus.max_valid = 1'b0;
    tick(); tick();
    checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", bus.pixel_valid); end
    checks++; if (bus.pixel_out !== 8'h00) begin errors++; $display("FAIL rst_pixel got=%h want=00", bus.pixel_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", bus.done); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_terr got=%b want=0", bus.timeout_err); end
    checks++; if (bus.result_count !== 10'd0) begin errors++; $display("FAIL rst_count got=%0d want=0", bus.result_count); end
    reset = 1'b0;
    tick();
  endtask

  task automatic load_frame();
    for (int a = 0; a < FRAME; a++) begin
      model[a] = 8'(a);
      bus.wr_en = 1'b1; bus.wr_addr = 10'(a); bus.wr_data = 8'(a);
      tick();
    end
    bus.wr_en = 1'b0;
    tick();
  endtask

  task automatic test_stream_gap0();
    run_frame(0, 169, 100, 8, 0, 0);
    checks++; if (o_timed_out != 0) begin errors++; $display("FAIL g0_finish got=timeout want=done"); end
    checks++; if (o_start_busy != 1) begin errors++; $display("FAIL g0_busy_start got=%0d want=1", o_start_busy); end
    checks++; if (o_pix != FRAME) begin errors++; $display("FAIL g0_pixels got=%0d want=%0d", o_pix, FRAME); end
    checks++; if (o_bad_data != 0) begin errors++; $display("FAIL g0_data bad=%0d want=0", o_bad_data); end
    checks++; if (o_first != 2) begin errors++; $display("FAIL g0_first_valid got=%0d want=2", o_first); end
    checks++; if (o_bad_space != 0) begin errors++; $display("FAIL g0_spacing bad=%0d want=0", o_bad_space); end
    checks++; if (o_busy_low != 0) begin errors++; $display("FAIL g0_busy_low got=%0d want=0", o_busy_low); end
    checks++; if (o_done_cyc != 1444) begin errors++; $display("FAIL g0_done_cycle got=%0d want=1444", o_done_cyc); end
    checks++; if (o_cnt_done != 169) begin errors++; $display("FAIL g0_count got=%0d want=169", o_cnt_done); end
    checks++; if (o_terr_done != 0) begin errors++; $display("FAIL g0_terr got=%0d want=0", o_terr_done); end
    checks++; if (o_after_done != 0 || o_after_busy != 0) begin
      errors++; $display("FAIL g0_after_done done=%0d busy=%0d want=0,0", o_after_done, o_after_busy);
    end
  endtask

  task automatic test_gap3_saturate();
    run_frame(3, 200, 10, 2, 0, 0);
    checks++; if (o_pix != FRAME) begin errors++; $display("FAIL g3_pixels got=%0d want=%0d", o_pix, FRAME); end
    checks++; if (o_bad_data != 0) begin errors++; $display("FAIL g3_data bad=%0d want=0", o_bad_data); end
    checks++; if (o_last - o_first + 1 != 3133) begin
      errors++; $display("FAIL g3_span got=%0d want=3133", o_last - o_first + 1);
    end
    checks++; if (o_bad_space != 0) begin errors++; $display("FAIL g3_spacing bad=%0d want=0", o_bad_space); end
    checks++; if (o_bad_hold != 0) begin errors++; $display("FAIL g3_hold bad=%0d want=0", o_bad_hold); end
    checks++; if (o_done_cyc != 3134) begin errors++; $display("FAIL g3_done_cycle got=%0d want=3134", o_done_cyc); end
    checks++; if (o_cnt_done != 169) begin errors++; $display("FAIL g3_saturate got=%0d want=169", o_cnt_done); end
    checks++; if (o_done_cnt != 1 || o_terr_done != 0) begin
      errors++; $display("FAIL g3_done_terr dones=%0d terr=%0d want=1,0", o_done_cnt, o_terr_done);
    end
  endtask

  task automatic test_timeout();
    run_frame(0, 100, 100, 8, 0, 0);
    checks++; if (o_done_cyc != 4880) begin errors++; $display("FAIL to_done_cycle got=%0d want=4880", o_done_cyc); end
    checks++; if (o_terr_done != 1) begin errors++; $display("FAIL to_terr got=%0d want=1", o_terr_done); end
    checks++; if (o_cnt_done != 100) begin errors++; $display("FAIL to_count got=%0d want=100", o_cnt_done); end
    bus.max_valid = 1'b1;
    tick(); tick(); tick();
    bus.max_valid = 1'b0;
    tick();
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b want=1", bus.timeout_err); end
    checks++; if (bus.result_count !== 10'd100) begin
      errors++; $display("FAIL idle_max_valid got=%0d want=100", bus.result_count);
    end
  endtask

  task automatic test_ignore_in_stream();
    run_frame(0, 169, 100, 8, 300, 0);
    checks++; if (o_start_terr != 0 || o_start_cnt != 0) begin
      errors++; $display("FAIL start_clears terr=%0d count=%0d want=0,0", o_start_terr, o_start_cnt);
    end
    checks++; if (o_pix != FRAME || o_done_cnt != 1) begin
      errors++; $display("FAIL ign_restart pixels=%0d dones=%0d want=%0d,1", o_pix, o_done_cnt, FRAME);
    end
    run_frame(0, 169, 100, 8, 0, 0);
    checks++; if (o_bad_data != 0 || o_pix != FRAME) begin
      errors++; $display("FAIL ign_write bad=%0d pixels=%0d want=0,%0d", o_bad_data, o_pix, FRAME);
    end
  endtask

  task automatic test_reset_abort();
    run_frame(0, 0, 1, 1, 0, 400);
    checks++; if (o_aborted != 1) begin errors++; $display("FAIL abort_reach got=%0d want=1", o_aborted); end
    checks++; if (o_abort_valid != 0 || o_abort_busy != 0) begin
      errors++; $display("FAIL abort_state valid=%0d busy=%0d want=0,0", o_abort_valid, o_abort_busy);
    end
    checks++; if (o_done_cnt != 0) begin errors++; $display("FAIL abort_done got=%0d want=0", o_done_cnt); end
    run_frame(0, 169, 100, 8, 0, 0);
    checks++; if (o_pix != FRAME || o_bad_data != 0 || o_first != 2) begin
      errors++; $display("FAIL abort_restream pixels=%0d bad=%0d first=%0d want=%0d,0,2",
                         o_pix, o_bad_data, o_first, FRAME);
    end
    checks++; if (o_done_cnt != 1) begin errors++; $display("FAIL abort_restream_done got=%0d want=1", o_done_cnt); end
  endtask

  initial begin
    test_reset();
    load_frame();
    test_stream_gap0();
    test_gap3_saturate();
    test_timeout();
    test_ignore_in_stream();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
